// File: rtl/axi_write_master_if.sv
// AXI4 write channel bundle (AW, W, B) between the write-back master and the slave.
// Master drives AW/W payload and bready; slave drives the ready/response side.
interface axi_write_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_write_master.sv
// AXI4 INCR burst write-back master: one cache line per burst, AW -> W -> B.
// Define AXI_WRITE_AW_W_OVERLAP_EN to issue AW and W beats concurrently.
module axi_write_master #(
    parameter int         _REQ_DATA_WIDTH = 256,
    parameter logic [7:0] _AW_LEN         = 8'h7,
    parameter logic [2:0] _AW_SIZE        = 3'b010,
    parameter logic [1:0] _AW_BURST       = 2'b01,
    parameter int         ADDR_WIDTH      = 32,
    parameter int         AXI_DATA_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_req_valid,
    output logic                       write_req_ready,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [_REQ_DATA_WIDTH-1:0] write_data,
    output logic                       write_resp_valid,
    output logic                       write_resp_err,
    axi_write_master_if.master         axi
);
    localparam int NBEATS = int'(_AW_LEN) + 1;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF    = $clog2(_REQ_DATA_WIDTH / 8);
    localparam logic [BW-1:0] LAST = BW'(_AW_LEN);

    generate
        if (_REQ_DATA_WIDTH != NBEATS * AXI_DATA_WIDTH) begin : g_width_check
            $error("axi_write_master: line width must equal beats * beat width");
        end
    endgenerate

`ifdef AXI_WRITE_AW_W_OVERLAP_EN
    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;
`endif

    state_t state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [NBEATS-1:0][AXI_DATA_WIDTH-1:0] line_reg;
    logic load;
    logic aw_v;
    logic w_v;
    logic b_r;
    logic resp_v;
    logic last_beat;
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
    logic aw_done, aw_done_nxt;
    logic w_done, w_done_nxt;
    logic aw_ok, w_ok;
`endif
    logic unused;

    assign last_beat = (beat_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_reg <= '0;
            line_reg <= '0;
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
            aw_done  <= aw_done_nxt;
            w_done   <= w_done_nxt;
`endif
            if (load) begin
                addr_reg <= {write_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                line_reg <= write_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        load      = 1'b0;
        aw_v      = 1'b0;
        w_v       = 1'b0;
        b_r       = 1'b0;
        resp_v    = 1'b0;
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        aw_ok       = 1'b0;
        w_ok        = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (write_req_valid) begin
                    load = 1'b1;
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
                    state_nxt = ADDR_DATA;
`else
                    state_nxt = ADDR;
`endif
                end
            end
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
            ADDR_DATA: begin
                aw_v  = !aw_done;
                w_v   = !w_done;
                aw_ok = aw_done | (aw_v & axi.awready);
                w_ok  = w_done;
                if (w_v && axi.wready) begin
                    if (last_beat) begin
                        beat_nxt = '0;
                        w_ok     = 1'b1;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
                // AW and the last W may complete in either order
                if (aw_ok && w_ok) begin
                    state_nxt   = RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_ok;
                    w_done_nxt  = w_ok;
                end
            end
`else
            ADDR: begin
                aw_v = 1'b1;
                if (axi.awready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                w_v = 1'b1;
                if (axi.wready) begin
                    if (last_beat) begin
                        beat_nxt  = '0;
                        state_nxt = RESP;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
`endif
            RESP: begin
                b_r = 1'b1;
                if (axi.bvalid) begin
                    resp_v    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // gated so ready stays low while reset is held
    assign write_req_ready  = rst_n && (state == IDLE);
    assign write_resp_valid = resp_v;
    assign write_resp_err   = resp_v & axi.bresp[1];

    assign axi.awvalid = aw_v;
    assign axi.awaddr  = addr_reg;
    assign axi.awlen   = _AW_LEN;
    assign axi.awsize  = _AW_SIZE;
    assign axi.awburst = _AW_BURST;
    assign axi.wvalid  = w_v;
    assign axi.wdata   = line_reg[beat_cnt];
    assign axi.wstrb   = '1;
    assign axi.wlast   = w_v & last_beat;
    assign axi.bready  = b_r;

    assign unused = ^{write_addr[OFF-1:0], axi.bresp[0]};
endmodule

// File: tb/tb_axi_write_master.sv
// Self-checking bench for axi_write_master: vector table, scoreboard queues,
// a responsive AXI slave model and hand-written back-to-back/reset/ordering cases.
module tb_axi_write_master;
    logic         clk;
    logic         rst_n;
    logic         write_req_valid;
    logic         write_req_ready;
    logic [31:0]  write_addr;
    logic [255:0] write_data;
    logic         write_resp_valid;
    logic         write_resp_err;

    axi_write_master_if axi ();

    axi_write_master dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_req_valid  (write_req_valid),
        .write_req_ready  (write_req_ready),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .write_resp_valid (write_resp_valid),
        .write_resp_err   (write_resp_err),
        .axi              (axi)
    );

`ifdef AXI_WRITE_AW_W_OVERLAP_EN
    localparam int LAT0 = 9;
`else
    localparam int LAT0 = 10;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] seed;
        logic [31:0] mask;
        int          awd;
        bit          wt;
        int          bd;
        logic [1:0]  br;
        logic [31:0] exp_addr;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int errors = 0;

    logic [44:0] exp_aw [$];
    logic [36:0] exp_w [$];
    bit          exp_e [$];

    int  cyc = 0;
    int  acc_cnt = 0, resp_cnt = 0, w_cnt = 0;
    int  last_acc_cyc = 0, last_resp_cyc = 0;
    int  last_aw_cyc = 0, last_wl_cyc = 0;

    int         aw_dly = 0, b_dly = 0;
    bit         wt = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int         aw_wait = 0, b_wait = 0;
    bit         tog = 1;
    bit         aw_seen = 0, wlast_seen = 0;
    bit         aw_stall = 0, w_stall = 0;
    logic [31:0] aw_hold = '0;
    logic [32:0] w_hold = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] seed,
                                             input logic [31:0] mask);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = (seed * 32'(k)) ^ mask;
        end
        return l;
    endfunction

    task automatic tick();
        bit aw_prior;
        aw_prior = aw_seen;
        axi.awready = (aw_wait >= aw_dly);
        axi.wready  = wt ? tog : 1'b1;
        tog = ~tog;
        if (aw_seen && wlast_seen) begin
            if (b_wait < b_dly) begin
                b_wait++;
                axi.bvalid = 1'b0;
            end else begin
                axi.bvalid = 1'b1;
                axi.bresp  = bresp_cfg;
            end
        end else begin
            axi.bvalid = 1'b0;
        end
        #1;
        if (acc_cnt > resp_cnt) chk("ready_while_busy", write_req_ready, 0);
        if (axi.bready) chk("bready_after_aw", aw_prior, 1);
        if (aw_stall) chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, aw_hold});
        if (w_stall) chk("w_hold", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, w_hold});
        aw_stall = axi.awvalid && !axi.awready;
        w_stall  = axi.wvalid && !axi.wready;
        aw_hold  = axi.awaddr;
        w_hold   = {axi.wlast, axi.wdata};
        if (axi.awvalid && !axi.awready) aw_wait++;
        if (axi.awvalid && axi.awready) begin
            if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else chk("aw", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst},
                     exp_aw.pop_front());
            aw_seen = 1;
            aw_wait = 0;
            last_aw_cyc = cyc;
        end
        if (axi.wvalid && axi.wready) begin
`ifndef AXI_WRITE_AW_W_OVERLAP_EN
            chk("w_after_aw", aw_prior, 1);
`endif
            if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
            else chk("w_beat", {axi.wdata, axi.wlast, axi.wstrb}, exp_w.pop_front());
            w_cnt++;
            if (axi.wlast) begin
                wlast_seen = 1;
                last_wl_cyc = cyc;
            end
        end
        if (write_resp_valid) begin
            if (exp_e.size() == 0) chk("resp_unexpected", 1, 0);
            else chk("resp_err", write_resp_err, exp_e.pop_front());
            resp_cnt++;
            last_resp_cyc = cyc;
        end
        if (axi.bvalid && axi.bready) begin
            aw_seen = 0;
            wlast_seen = 0;
            b_wait = 0;
        end
        if (write_req_valid && write_req_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_acc(input int tgt);
        int n = 0;
        while (acc_cnt < tgt && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (acc_cnt < tgt) begin
            errors++;
            $display("FAIL accept_timeout: accepted %0d required %0d", acc_cnt, tgt);
        end
    endtask

    task automatic wait_resp(input int tgt);
        int n = 0;
        while (resp_cnt < tgt && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (resp_cnt < tgt) begin
            errors++;
            $display("FAIL resp_timeout: pulses %0d required %0d", resp_cnt, tgt);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        aw_dly = v.awd;
        wt = v.wt;
        b_dly = v.bd;
        bresp_cfg = v.br;
        tog = 1;
        aw_wait = 0;
        b_wait = 0;
    endtask

    task automatic push_exp(input vec_t v, input logic [255:0] line);
        exp_aw.push_back({v.exp_addr, 8'd7, 3'd2, 2'd1});
        for (int k = 0; k < 8; k++) begin
            exp_w.push_back({line[k*32 +: 32], (k == 7), 4'hF});
        end
        exp_e.push_back(v.exp_err);
    endtask

    task automatic run_burst(input vec_t v, output int lat);
        logic [255:0] line;
        int a0, r0;
        line = mk_line(v.seed, v.mask);
        set_cfg(v);
        push_exp(v, line);
        a0 = acc_cnt;
        r0 = resp_cnt;
        write_addr = v.addr;
        write_data = line;
        write_req_valid = 1'b1;
        wait_acc(a0 + 1);
        write_req_valid = 1'b0;
        wait_resp(r0 + 1);
        lat = last_resp_cyc - last_acc_cyc;
    endtask

    initial begin
        vec_t va, vb;
        int lat, a0, r0, w0;

        vecs[0] = '{32'h8000_0014, 32'h1111_1111, 32'h0, 0, 1'b0, 0, 2'b00,
                    32'h8000_0000, 1'b0, LAT0};
        vecs[1] = '{32'h1234_567F, 32'h0BAD_F00D, 32'hDEAD_BEEF, 5, 1'b1, 0, 2'b00,
                    32'h1234_5660, 1'b0, -1};
        vecs[2] = '{32'h0000_0020, 32'h0101_0101, 32'hA5A5_5A5A, 0, 1'b0, 3, 2'b10,
                    32'h0000_0020, 1'b1, LAT0 + 3};
        vecs[3] = '{32'hFFFF_FFFF, 32'h7654_3210, 32'h0F0F_F0F0, 2, 1'b1, 1, 2'b11,
                    32'hFFFF_FFE0, 1'b1, -1};
        vecs[4] = '{32'h4000_0040, 32'h1357_9BDF, 32'h0, 0, 1'b0, 2, 2'b01,
                    32'h4000_0040, 1'b0, LAT0 + 2};

        rst_n = 1'b0;
        write_req_valid = 1'b0;
        write_addr = '0;
        write_data = '0;
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        axi.bvalid = 1'b0;
        axi.bresp = 2'b00;
        #1;
        chk("reset_outputs", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
            write_resp_valid, write_req_ready, axi.awaddr, axi.wdata}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", write_req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i], lat);
            if (vecs[i].exp_lat >= 0) chk("latency", lat, vecs[i].exp_lat);
        end

        // request held high with new data while the first burst is in flight
        va = '{32'h2000_0008, 32'h0001_0003, 32'h5555_0000, 0, 1'b0, 1, 2'b00,
               32'h2000_0000, 1'b0, -1};
        vb = '{32'h3000_003C, 32'h0300_0007, 32'h0000_AAAA, 0, 1'b0, 1, 2'b00,
               32'h3000_0020, 1'b0, -1};
        set_cfg(va);
        push_exp(va, mk_line(va.seed, va.mask));
        push_exp(vb, mk_line(vb.seed, vb.mask));
        a0 = acc_cnt;
        r0 = resp_cnt;
        write_addr = va.addr;
        write_data = mk_line(va.seed, va.mask);
        write_req_valid = 1'b1;
        wait_acc(a0 + 1);
        write_addr = vb.addr;
        write_data = mk_line(vb.seed, vb.mask);
        wait_acc(a0 + 2);
        chk("b2b_resp_before_accept", resp_cnt - r0, 1);
        chk("b2b_accept_cycle", last_acc_cyc, last_resp_cyc + 1);
        write_req_valid = 1'b0;
        wait_resp(r0 + 2);

        // reset while beat 4 is on the W channel
        va = '{32'h6000_0010, 32'h0F1E_2D3C, 32'h1234_0000, 0, 1'b0, 0, 2'b00,
               32'h6000_0000, 1'b0, -1};
        set_cfg(va);
        push_exp(va, mk_line(va.seed, va.mask));
        w0 = w_cnt;
        a0 = acc_cnt;
        write_addr = va.addr;
        write_data = mk_line(va.seed, va.mask);
        write_req_valid = 1'b1;
        wait_acc(a0 + 1);
        write_req_valid = 1'b0;
        begin
            int n = 0;
            while (w_cnt < w0 + 4 && n < 50) begin
                tick();
                n++;
            end
        end
        chk("beats_before_reset", w_cnt - w0, 4);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_burst", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
            write_resp_valid, write_req_ready, axi.awaddr, axi.wdata}, 0);
        exp_aw.delete();
        exp_w.delete();
        exp_e.delete();
        aw_seen = 0;
        wlast_seen = 0;
        aw_stall = 0;
        w_stall = 0;
        resp_cnt = acc_cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("ready_after_mid_reset", write_req_ready, 1);
        va.seed = 32'h2468_ACE0;
        va.exp_err = 1'b1;
        va.br = 2'b10;
        run_burst(va, lat);
        chk("latency_after_reset", lat, LAT0);

        // AW held off until well after the last W beat could have gone
        va = '{32'h7000_0004, 32'h0BEE_F001, 32'h0, 12, 1'b0, 0, 2'b00,
               32'h7000_0000, 1'b0, -1};
        run_burst(va, lat);
        chk("resp_after_aw", last_resp_cyc > last_aw_cyc, 1);
`ifdef AXI_WRITE_AW_W_OVERLAP_EN
        chk("wlast_before_aw", last_wl_cyc < last_aw_cyc, 1);
`else
        chk("wlast_after_aw", last_wl_cyc > last_aw_cyc, 1);
`endif
        chk("queues_drained", exp_aw.size() + exp_w.size() + exp_e.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
